// File: rtl/pkt_arb_if.sv
// Byte-stream handshake bundle between NP requesters and the packet arbiter,
// plus the packet control codes carried alongside every byte.
`ifndef PCC_DATA
`define PCC_DATA   2'b00
`define PCC_SOP    2'b01
`define PCC_EOP    2'b10
`define PCC_BADEOP 2'b11
`endif

interface pkt_arb_if #(
  parameter int NP = 4
);
  logic [8*NP-1:0] c_data;
  logic [2*NP-1:0] c_code;
  logic [NP-1:0]   c_srdy;
  logic [NP-1:0]   c_drdy;
  logic [7:0]      p_data;
  logic [1:0]      p_code;
  logic [2:0]      p_port;
  logic            p_srdy;
  logic            p_drdy;

  modport master (
    output c_data, c_code, c_srdy, p_drdy,
    input  c_drdy, p_data, p_code, p_port, p_srdy
  );

  modport slave (
    input  c_data, c_code, c_srdy, p_drdy,
    output c_drdy, p_data, p_code, p_port, p_srdy
  );
endinterface

// File: rtl/pkt_arb.sv
// Packet-level round-robin arbiter: merges NP byte streams into one registered
// output stream, holding each grant for a whole packet and truncating overlong ones.
module pkt_arb #(
  parameter int NP     = 4,
  parameter int MAXLEN = 1518
) (
  input  logic     clk,
  input  logic     reset,
  pkt_arb_if.slave bus
);

  localparam int GW = (NP > 1) ? $clog2(NP) : 1;
  localparam int CW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  typedef enum logic [1:0] {IDLE, LOCKED, FLUSH} state_t;

  state_t          state;
  logic [GW-1:0]   gnt;
  logic [GW-1:0]   last;
  logic [GW-1:0]   winner;
  logic            found;
  logic [CW-1:0]   count;
  logic [NP-1:0]   drdy;
  logic [7:0]      sel_data;
  logic [1:0]      sel_code;
  logic            xfer;
  logic            is_eop;
  logic [7:0]      out_data;
  logic [1:0]      out_code;
  logic [2:0]      out_port;
  logic            out_valid;

  // Round-robin search starts just after the previous packet's owner.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = last;
    found  = 1'b0;
    for (int k = 1; k <= NP; k++) begin
      if (!found && bus.c_srdy[(int'(last) + k) % NP]) begin
        found  = 1'b1;
        winner = GW'((int'(last) + k) % NP);
      end
    end
  end

  // LOCKED accepts only when the output register is free or draining this cycle;
  // FLUSH swallows the rest of a truncated packet unconditionally.
  always_comb begin
    drdy = '0;
    if (!reset) begin
      if (state == LOCKED)
        drdy[gnt] = ~out_valid | bus.p_drdy;
      else if (state == FLUSH)
        drdy[gnt] = 1'b1;
    end
  end

  assign sel_data = bus.c_data[8*int'(gnt) +: 8];
  assign sel_code = bus.c_code[2*int'(gnt) +: 2];
  assign xfer     = bus.c_srdy[gnt] & drdy[gnt];
  assign is_eop   = (sel_code == `PCC_EOP) || (sel_code == `PCC_BADEOP);

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      last      <= GW'(NP - 1);
      count     <= '0;
      out_data  <= '0;
      out_code  <= '0;
      out_port  <= '0;
      out_valid <= 1'b0;
    end else begin
      // An input load below overrides this clear, giving back-to-back throughput.
      if (out_valid && bus.p_drdy)
        out_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (found) begin
            gnt   <= winner;
            count <= '0;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer) begin
            out_data  <= sel_data;
            out_port  <= 3'(gnt);
            out_valid <= 1'b1;
            count     <= count + CW'(1);
            if (is_eop) begin
              out_code <= sel_code;
              last     <= gnt;
              state    <= IDLE;
            end else if (count == CW'(MAXLEN - 1)) begin
              out_code <= `PCC_BADEOP;
              last     <= gnt;
              state    <= FLUSH;
            end else begin
              out_code <= sel_code;
            end
          end
        end
        FLUSH: begin
          if (xfer && is_eop)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.c_drdy = drdy;
  assign bus.p_data = out_data;
  assign bus.p_code = out_code;
  assign bus.p_port = out_port;
  assign bus.p_srdy = out_valid;

endmodule

// File: tb/tb_pkt_arb.sv
// Self-checking bench for pkt_arb: directed scenarios plus randomized traffic,
// scored against per-port expected-output queues built from the packet rules.
module tb_pkt_arb;

  localparam int NP     = 4;
  localparam int MAXLEN = 4;
  localparam logic [1:0] C_DATA = 2'b00;
  localparam logic [1:0] C_SOP  = 2'b01;
  localparam logic [1:0] C_EOP  = 2'b10;
  localparam logic [1:0] C_BAD  = 2'b11;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] code;
  } beat_t;

  typedef struct {
    int         port;
    logic [1:0] code;
    int         cyc;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pkt_arb_if #(.NP(NP)) bus ();

  pkt_arb #(.NP(NP), .MAXLEN(MAXLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]    s_data [NP];
  logic [1:0]    s_code [NP];
  logic [NP-1:0] s_srdy;

  always_comb begin
    bus.c_data = '0;
    bus.c_code = '0;
    for (int i = 0; i < NP; i++) begin
      bus.c_data[8*i +: 8] = s_data[i];
      bus.c_code[2*i +: 2] = s_code[i];
    end
    bus.c_srdy = s_srdy;
  end

  beat_t tx_q [NP][$];
  beat_t sb_q [NP][$];
  obs_t  out_log[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int gap_pct  = 0;
  int drdy_pct = 100;
  int stall_at = -1;
  int stall_len = 0;
  int stall_port = 0;
  int stall_left = 0;
  int open_port = -1;
  int gap_left [NP];

  logic [NP-1:0] in_x;
  logic          out_x;
  logic [7:0]    cap_data;
  logic [1:0]    cap_code;
  logic [2:0]    cap_port;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Expected output: first MAXLEN bytes of each packet, the MAXLEN-th forced to
  // BADEOP unless it already terminates the packet; the remainder never appears.
  task automatic add_pkt(input int p, input int len, input logic [1:0] end_code);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = 8'($urandom);
      if (k == len - 1)  b.code = end_code;
      else if (k == 0)   b.code = C_SOP;
      else               b.code = C_DATA;
      tx_q[p].push_back(b);
      if (k < MAXLEN) begin
        if (k == MAXLEN - 1 && b.code != C_EOP && b.code != C_BAD)
          b.code = C_BAD;
        sb_q[p].push_back(b);
      end
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NP; i++)
      if (tx_q[i].size() != 0 || sb_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic score(input logic [7:0] d, input logic [1:0] c, input logic [2:0] p);
    obs_t  o;
    beat_t e;
    int    port = int'(p);
    if (open_port >= 0) check("no_interleave", port, open_port);
    check("port_range", port < NP, 1);
    if (port >= NP) return;
    check("byte_expected", sb_q[port].size() > 0, 1);
    if (sb_q[port].size() > 0) begin
      e = sb_q[port].pop_front();
      check("out_data", d, e.data);
      check("out_code", c, e.code);
    end
    open_port = (c == C_EOP || c == C_BAD) ? -1 : port;
    o.port = port;
    o.code = c;
    o.cyc  = cyc;
    out_log.push_back(o);
    if (out_log.size() == stall_at) stall_left = stall_len;
  endtask

  // One clock: retire last edge's handshakes, drive new inputs at the negedge,
  // then sample what the next rising edge will transfer.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NP; i++)
      if (in_x[i] && tx_q[i].size() > 0) void'(tx_q[i].pop_front());
    if (out_x) score(cap_data, cap_code, cap_port);
    for (int i = 0; i < NP; i++) begin
      if (!(s_srdy[i] && !in_x[i])) begin
        s_srdy[i] = 1'b0;
        if (tx_q[i].size() > 0) begin
          if (gap_left[i] > 0) gap_left[i]--;
          else if (int'($urandom_range(99)) < gap_pct) gap_left[i] = int'($urandom_range(3, 1));
          else begin
            s_srdy[i] = 1'b1;
            s_data[i] = tx_q[i][0].data;
            s_code[i] = tx_q[i][0].code;
          end
        end
      end
    end
    if (stall_left > 0) bus.p_drdy = 1'b0;
    else bus.p_drdy = (int'($urandom_range(99)) < drdy_pct);
    #1;
    if (stall_left > 0) begin
      check("stall_srdy", bus.p_srdy, 1);
      check("stall_data", bus.p_data, sb_q[stall_port].size() > 0 ? sb_q[stall_port][0].data : 8'h00);
      check("stall_drdy", bus.c_drdy[stall_port], 0);
      stall_left--;
    end
    check("drdy_onehot", $countones(bus.c_drdy) <= 1, 1);
    in_x     = s_srdy & bus.c_drdy;
    out_x    = bus.p_srdy & bus.p_drdy;
    cap_data = bus.p_data;
    cap_code = bus.p_code;
    cap_port = bus.p_port;
  endtask

  task automatic run_drain(input int budget);
    int c = 0;
    while (!all_empty() && c < budget) begin
      step();
      c++;
    end
    check("drained", all_empty(), 1);
    repeat (4) step();
  endtask

  task automatic run_until_out(input int target, input int budget);
    int c = 0;
    while (out_log.size() < target && c < budget) begin
      step();
      c++;
    end
    check("reached_out", out_log.size() >= target, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    s_srdy = '1;
    bus.p_drdy = 1'b1;
    @(negedge clk);
    #1;
    check("rst_srdy", bus.p_srdy, 0);
    check("rst_data", bus.p_data, 0);
    check("rst_code", bus.p_code, 0);
    check("rst_port", bus.p_port, 0);
    check("rst_drdy", bus.c_drdy, 0);
    reset = 1'b0;
    s_srdy = '0;
    for (int i = 0; i < NP; i++) begin
      tx_q[i].delete();
      sb_q[i].delete();
      gap_left[i] = 0;
    end
    in_x = '0;
    out_x = 1'b0;
    open_port = -1;
    stall_left = 0;
    out_log.delete();
    @(negedge clk);
    #1;
    check("post_rst_srdy", bus.p_srdy, 0);
    check("post_rst_drdy", bus.c_drdy, 0);
  endtask

  initial begin
    int exp_ports[6];
    for (int i = 0; i < NP; i++) begin
      s_data[i] = '0;
      s_code[i] = '0;
    end
    s_srdy = '0;
    bus.p_drdy = 1'b0;
    in_x = '0;
    out_x = 1'b0;

    // Ports 0 and 2 together: full packets back to back, one idle cycle apart.
    do_reset();
    add_pkt(0, 3, C_EOP);
    add_pkt(2, 3, C_EOP);
    run_drain(100);
    exp_ports = '{0, 0, 0, 2, 2, 2};
    check("two_port_count", out_log.size(), 6);
    if (out_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) check("two_port_seq", out_log[i].port, exp_ports[i]);
      check("throughput", out_log[1].cyc - out_log[0].cyc, 1);
      check("idle_gap", out_log[3].cyc - out_log[2].cyc, 2);
    end

    // All ports requesting 1-byte packets: strict rotation from port 0.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) add_pkt(p, 1, C_EOP);
    run_drain(200);
    exp_ports = '{0, 1, 2, 3, 0, 1};
    check("rr_count", out_log.size(), 8);
    if (out_log.size() >= 6)
      for (int i = 0; i < 6; i++) check("rr_seq", out_log[i].port, exp_ports[i]);

    // Downstream stall for 5 cycles mid-packet.
    do_reset();
    stall_port = 1;
    stall_len = 5;
    stall_at = 1;
    add_pkt(1, 4, C_EOP);
    run_drain(100);
    stall_at = -1;
    check("stall_count", out_log.size(), 4);

    // Overlong packet is cut at MAXLEN; a following packet still gets through.
    do_reset();
    add_pkt(1, 6, C_EOP);
    add_pkt(1, 2, C_EOP);
    run_drain(100);
    check("trunc_count", out_log.size(), 6);
    if (out_log.size() >= 4) check("trunc_code", out_log[3].code, C_BAD);

    // Reset mid-packet drops the in-flight byte and restarts rotation at port 0.
    do_reset();
    add_pkt(0, 1, C_EOP);
    run_drain(50);
    out_log.delete();
    add_pkt(2, 4, C_EOP);
    run_until_out(1, 50);
    check("pre_reset_srdy", bus.p_srdy, 1);
    do_reset();
    add_pkt(1, 1, C_EOP);
    add_pkt(0, 1, C_EOP);
    run_drain(50);
    check("rst_rr_count", out_log.size(), 2);
    if (out_log.size() >= 1) check("rst_rr_first", out_log[0].port, 0);

    // Randomized traffic with input gaps and downstream backpressure.
    do_reset();
    gap_pct = 30;
    drdy_pct = 70;
    for (int n = 0; n < 60; n++)
      add_pkt(int'($urandom_range(NP - 1)), int'($urandom_range(6, 1)),
              ($urandom_range(3) == 0) ? C_BAD : C_EOP);
    run_drain(5000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/pkt_arb.md
PKT_ARB -- requirements
Module: pkt_arb

Interface
REQ-001 Parameter NP, 4, number of byte-stream requesters, 2..8.
REQ-002 Parameter MAXLEN, 1518, maximum bytes per packet, 2..65535.
REQ-003 Port clk input 1, single clock; all state SHALL change on its rising edge.
REQ-004 Port reset input 1, synchronous, active-high reset.
REQ-005 Port c_data input 8*NP, byte for requester i on bits [8i+7:8i].
REQ-006 Port c_code input 2*NP, `PCC_* code for requester i on bits [2i+1:2i].
REQ-007 Port c_srdy input NP, per-requester source-ready.
REQ-008 Port c_drdy output NP, per-requester destination-ready (combinational).
REQ-009 Port p_data output 8, registered output byte to the downstream concentrator.
REQ-010 Port p_code output 2, registered `PCC_* code accompanying p_data.
REQ-011 Port p_port output 3, registered index of the requester that sourced p_data.
REQ-012 Port p_srdy output 1, registered output-valid.
REQ-013 Port p_drdy input 1, downstream ready.

Function
REQ-014 Transfer on the input side SHALL occur when c_srdy[i] & c_drdy[i]; on the output side, when p_srdy & p_drdy.
REQ-015 Arbitration SHALL be packet-level; the grant is held from the first byte of a packet through the byte carrying `PCC_EOP or `PCC_BADEOP.
REQ-016 States SHALL be IDLE, LOCKED and FLUSH; reset state SHALL be IDLE.
REQ-017 In IDLE, c_drdy SHALL be all zero; if any c_srdy is set, the winner SHALL be the first asserted requester in the order last+1, last+2, ... (mod NP), gnt SHALL take the winner's index, and the state SHALL move to LOCKED the next cycle; IDLE-to-first-transfer latency is 1 cycle.
REQ-018 In LOCKED, c_drdy[gnt] SHALL equal (~p_srdy | p_drdy); all other c_drdy bits SHALL be 0.
REQ-019 In LOCKED, on an input transfer, p_data, p_code and p_port SHALL load c_data[gnt], c_code[gnt] and gnt, and p_srdy SHALL be 1 the next cycle.
REQ-020 p_srdy SHALL clear after an output transfer with no simultaneous input load; a simultaneous load and unload SHALL keep p_srdy at 1 with full throughput (1 byte/cycle).
REQ-021 A byte counter SHALL count bytes of the current packet; it SHALL clear on entry to LOCKED and increment on each LOCKED transfer.
REQ-022 A LOCKED transfer with code `PCC_EOP or `PCC_BADEOP SHALL set last=gnt and move the state to IDLE.
REQ-023 If the counter equals MAXLEN-1 and the byte code is neither EOP nor BADEOP, the loaded p_code SHALL be forced to `PCC_BADEOP, last SHALL be set to gnt, and the state SHALL move to FLUSH.
REQ-024 In FLUSH, c_drdy[gnt] SHALL be 1 (others 0); accepted bytes SHALL be discarded without loading p_*; a discarded EOP/BADEOP byte SHALL move the state to IDLE.
REQ-025 The p_* registers SHALL be independent of state; a pending output byte SHALL drain through IDLE and FLUSH.
REQ-026 p_port SHALL be zero-extended from the gnt width to 3 bits.

Reset
REQ-027 Reset SHALL set p_srdy=0, p_data=0, p_code=0, p_port=0, gnt=0, last=NP-1, count=0, state=IDLE; c_drdy SHALL be 0 during reset.
REQ-028 Reset asserted mid-packet SHALL drop the in-flight output byte, and no partial-packet state SHALL survive reset.

Verification
REQ-029 Ports 0 and 2 request together after reset, with a 3-byte packet each (codes SOP, DATA, EOP) and p_drdy=1 -> p_port sequence is 0,0,0,2,2,2, with one idle cycle between packets.
REQ-030 All 4 ports request continuously with 1-byte EOP packets -> grants 0,1,2,3,0 in round-robin order; no byte from another port is interleaved inside a packet.
REQ-031 p_drdy=0 for 5 cycles mid-packet -> p_srdy stays 1, p_data is stable, c_drdy[gnt]=0, and no byte is lost or duplicated.
REQ-032 With MAXLEN=4, port 1 sends 6 bytes ending in EOP -> output shows 4 bytes, the 4th with code BADEOP; bytes 5-6 are consumed and discarded; the state returns to IDLE.
REQ-033 Reset is asserted for 1 cycle while LOCKED with p_srdy=1 -> the next cycle shows p_srdy=0 and state IDLE, and arbitration restarts at port 0.
